// File: rtl/wb_slave_decoder_if.sv
// Wishbone bundle between one bus master, the address decoder and NSLAVES peripherals.
// The "slave" modport is the decoder's view; "master" is the master plus peripherals.
interface wb_slave_decoder_if #(
  parameter int unsigned NSLAVES = 4
);
  logic [31:0]           wbm_adr_i;
  logic [31:0]           wbm_dat_i;
  logic [3:0]            wbm_sel_i;
  logic                  wbm_we_i;
  logic                  wbm_cyc_i;
  logic                  wbm_stb_i;
  logic [2:0]            wbm_cti_i;
  logic [1:0]            wbm_bte_i;
  logic [31:0]           wbm_dat_o;
  logic                  wbm_ack_o;
  logic                  wbm_err_o;
  logic                  wbm_rty_o;

  logic [15:0]           wbs_adr_o;
  logic [31:0]           wbs_dat_o;
  logic [3:0]            wbs_sel_o;
  logic                  wbs_we_o;
  logic [2:0]            wbs_cti_o;
  logic [1:0]            wbs_bte_o;
  logic [NSLAVES-1:0]    wbs_cyc_o;
  logic [NSLAVES-1:0]    wbs_stb_o;
  logic [32*NSLAVES-1:0] wbs_dat_i;
  logic [NSLAVES-1:0]    wbs_ack_i;
  logic [NSLAVES-1:0]    wbs_err_i;
  logic [NSLAVES-1:0]    wbs_rty_i;

  modport slave (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o, wbs_cyc_o, wbs_stb_o,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
  );

  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o, wbs_cyc_o, wbs_stb_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
  );
endinterface

// File: rtl/wb_slave_decoder.sv
// Single-master Wishbone decoder: routes a 32-bit address to one of NSLAVES 16-bit windows,
// registers the slave response and terminates unmapped or silent accesses with an error.
module wb_slave_decoder #(
  parameter logic [11:0] BASE_HI = 12'h100,
  parameter int unsigned NSLAVES = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input logic               wb_clk_i,
  input logic               wb_rst_i,
  wb_slave_decoder_if.slave bus
);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StActive, StResp} state_e;

  state_e             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [31:0]        rdat_q, rdat_d;
  logic               ack_q, ack_d, err_q, err_d, rty_q, rty_d;
  logic [3:0]         slot_q;
  logic [15:0]        adr_q;
  logic [31:0]        wdat_q;
  logic [3:0]         sel_q;
  logic               we_q;
  logic [2:0]         cti_q;
  logic [1:0]         bte_q;
  logic               accept, mapped;
  logic               sel_ack, sel_err, sel_rty;
  logic [31:0]        sel_dat;
  logic [NSLAVES-1:0] strobe;

  assign mapped = (bus.wbm_adr_i[31:20] == BASE_HI) &&
                  ({28'd0, bus.wbm_adr_i[19:16]} < NSLAVES);

  // Only the addressed slave's response is visible; the rest are ignored.
  always_comb begin
    sel_ack = 1'b0;
    sel_err = 1'b0;
    sel_rty = 1'b0;
    sel_dat = '0;
    strobe  = '0;
    for (int unsigned k = 0; k < NSLAVES; k++) begin
      if (slot_q == 4'(k)) begin
        sel_ack   = bus.wbs_ack_i[k];
        sel_err   = bus.wbs_err_i[k];
        sel_rty   = bus.wbs_rty_i[k];
        sel_dat   = bus.wbs_dat_i[32*k +: 32];
        strobe[k] = (state_q == StActive);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rty_d   = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.wbm_cyc_i && bus.wbm_stb_i) begin
          accept = 1'b1;
          cnt_d  = '0;
          if (mapped) begin
            state_d = StActive;
          end else begin
            state_d = StResp;
            err_d   = 1'b1;
            rdat_d  = '0;
          end
        end
      end
      StActive: begin
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        // A master abort wins over any same-cycle slave response.
        if (!bus.wbm_cyc_i) begin
          state_d = StIdle;
        end else if (sel_err) begin
          state_d = StResp;
          err_d   = 1'b1;
        end else if (sel_rty) begin
          state_d = StResp;
          rty_d   = 1'b1;
        end else if (sel_ack) begin
          state_d = StResp;
          ack_d   = 1'b1;
          rdat_d  = sel_dat;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StResp;
          err_d   = 1'b1;
          rdat_d  = '0;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
      slot_q  <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cti_q   <= '0;
      bte_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
      if (accept) begin
        slot_q <= bus.wbm_adr_i[19:16];
        adr_q  <= bus.wbm_adr_i[15:0];
        wdat_q <= bus.wbm_dat_i;
        sel_q  <= bus.wbm_sel_i;
        we_q   <= bus.wbm_we_i;
        cti_q  <= bus.wbm_cti_i;
        bte_q  <= bus.wbm_bte_i;
      end
    end
  end

  assign bus.wbm_dat_o = rdat_q;
  assign bus.wbm_ack_o = ack_q;
  assign bus.wbm_err_o = err_q;
  assign bus.wbm_rty_o = rty_q;
  assign bus.wbs_adr_o = adr_q;
  assign bus.wbs_dat_o = wdat_q;
  assign bus.wbs_sel_o = sel_q;
  assign bus.wbs_we_o  = we_q;
  assign bus.wbs_cti_o = cti_q;
  assign bus.wbs_bte_o = bte_q;
  assign bus.wbs_cyc_o = strobe;
  assign bus.wbs_stb_o = strobe;
endmodule
